sha_256_core_scheduler: RTL

//  Shares one sha_256_accelerator core between NUM_REQ requesters. Round-robin grant per

---
 rtl/sha_256_core_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sha_256_core_scheduler.sv
// Purpose: shares one SHA-256 core between NUM_REQ block sources, round-robin per message, digest returned tagged with owner id.
// Latency: grant + core reset + arm = 3 cycles before the first block loads; each block then waits on core output_valid.
// Backpressure: req_ready pulses once per accepted block; rsp held until rsp_ready; ena=0 freezes scheduler and core.
module sha_256_core_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    input  logic [NUM_REQ*512-1:0] req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [255:0]           rsp_hash,
    output logic                   err,
    output logic                   busy,
    output logic                   core_rst,
    output logic                   core_ena,
    output logic [511:0]           core_input_data,
    output logic                   core_input_valid,
    input  logic [255:0]           core_output_hash,
    input  logic                   core_output_valid
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_ARM,
        S_LOAD,
        S_WAIT,
        S_NEXT,
        S_RESP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_after;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic [ID_W:0]     rr_sum;
    logic              last_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [ID_W+8:0]   data_base;

    // Core is held in reset by the global reset and for the single CRST cycle between messages.
    assign core_rst  = rst | (state == S_CRST);
    assign core_ena  = ena;
    assign data_base = {owner, 9'd0};
    assign core_input_data = req_data[data_base +: 512];

    // Pointer for the next arbitration round once the current owner is done or aborted.
    assign rr_after = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // First requesting index at or after the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (rr_sum >= (ID_W + 1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (ID_W + 1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[rr_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_sum[ID_W-1:0];
            end
        end
    end

    // Message-level FSM with all handshake outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            owner            <= '0;
            rr_ptr           <= '0;
            last_q           <= 1'b0;
            tmo_cnt          <= '0;
            req_ready        <= '0;
            core_input_valid <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_id           <= '0;
            rsp_hash         <= '0;
            err              <= 1'b0;
            busy             <= 1'b0;
        end else if (ena) begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        owner <= grant_idx;
                        busy  <= 1'b1;
                        state <= S_CRST;
                    end
                end
                S_CRST: begin
                    core_input_valid <= 1'b1;
                    state            <= S_ARM;
                end
                S_ARM: begin
                    req_ready <= NUM_REQ'(1) << owner;
                    state     <= S_LOAD;
                end
                S_LOAD: begin
                    last_q           <= req_last[owner];
                    req_ready        <= '0;
                    core_input_valid <= 1'b0;
                    state            <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_output_valid) begin
                        if (last_q) begin
                            rsp_hash  <= core_output_hash;
                            rsp_id    <= owner;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    // Core already sits in START_CHUNK with the chaining value kept.
                    if (req_valid[owner]) begin
                        req_ready        <= NUM_REQ'(1) << owner;
                        core_input_valid <= 1'b1;
                        state            <= S_LOAD;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT)) begin
                        err    <= 1'b1;
                        busy   <= 1'b0;
                        rr_ptr <= rr_after;
                        state  <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        rr_ptr    <= rr_after;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
